// File: rtl/rf_pkg.sv
// Shared helpers for multiport_register_file: address-width function, default word/address
// types and the write-port priority resolver used by both commit and forwarding paths.
package rf_pkg;

    localparam int unsigned RF_DATA_W    = 32;
    localparam int unsigned RF_NREGS     = 32;
    localparam int unsigned RF_MAX_PORTS = 16;

    function automatic int unsigned rf_aw(input int unsigned nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    localparam int unsigned RF_AW = rf_aw(RF_NREGS);

    typedef logic [RF_AW-1:0]        rf_addr_t;
    typedef logic [RF_DATA_W-1:0]    rf_word_t;
    typedef logic [RF_MAX_PORTS-1:0] rf_portvec_t;

    // Highest-numbered hitting port wins; -1 when no port hits.
    function automatic int rf_winner(input rf_portvec_t hit);
        int w;
        w = -1;
        for (int p = 0; p < RF_MAX_PORTS; p++) begin
            if (hit[p]) w = p;
        end
        return w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-producer tracker for the register file: reserve sets, any write clears, flush clears
// all (reserve wins), and rbusy is registered to line up with rdat.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 1,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned AW       = 5
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [NWR-1:0]           wen,
    input  logic [NWR-1:0][AW-1:0]   wsel,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_sel,
    input  logic                     sb_flush,
    input  logic [NRD-1:0][AW-1:0]   rsel,
    output logic [NRD-1:0]           rbusy
);

    logic [NREGS-1:0] pending_q, pending_d;
    logic [NRD-1:0]   rbusy_q, rbusy_d;

    always_comb begin
        pending_d = sb_flush ? '0 : pending_q;
        for (int p = 0; p < NWR; p++) begin
            if (wen[p]) pending_d[wsel[p]] = 1'b0;
        end
        // Applied last so a same-cycle reserve beats both write-clear and flush.
        if (rsv_en) pending_d[rsv_sel] = 1'b1;
        if (ZERO_REG != 0) pending_d[0] = 1'b0;
    end

    always_comb begin
        rbusy_d = '0;
        for (int r = 0; r < NRD; r++) begin
            rbusy_d[r] = pending_d[rsel[r]];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pending_q <= '0;
            rbusy_q   <= '0;
        end else begin
            pending_q <= pending_d;
            rbusy_q   <= rbusy_d;
        end
    end

    assign rbusy = rbusy_q;

endmodule

// File: rtl/multiport_register_file.sv
// NREGS x DATA_W register file, NRD registered read ports with same-cycle write forwarding.
// Define RF_SCOREBOARD_EN to add the pending-producer scoreboard and rbusy outputs.
module multiport_register_file
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 1,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = rf_aw(NREGS)
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic [NWR-1:0]              wen,
    input  logic [NWR-1:0][AW-1:0]      wsel,
    input  logic [NWR-1:0][DATA_W-1:0]  wdat,
    input  logic [NRD-1:0][AW-1:0]      rsel,
`ifdef RF_SCOREBOARD_EN
    input  logic                        rsv_en,
    input  logic [AW-1:0]               rsv_sel,
    input  logic                        sb_flush,
    output logic [NRD-1:0]              rbusy,
`endif
    output logic [NRD-1:0][DATA_W-1:0]  rdat
);

    logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NRD-1:0][DATA_W-1:0]   rdat_q, rdat_d;

    // Reg 0 never matches when hardwired, so its writes vanish from commit and forwarding alike.
    function automatic rf_portvec_t write_hits(input logic [AW-1:0] addr);
        rf_portvec_t hit;
        hit = '0;
        for (int p = 0; p < NWR; p++) begin
            hit[p] = wen[p] && (wsel[p] == addr);
        end
        if (ZERO_REG != 0 && addr == '0) hit = '0;
        return hit;
    endfunction

    function automatic logic [DATA_W-1:0] port_data(input int w);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int p = 0; p < NWR; p++) begin
            if (p == w) d = wdat[p];
        end
        return d;
    endfunction

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NREGS; i++) begin
            int w;
            w = rf_winner(write_hits(AW'(i)));
            if (w >= 0) regs_d[i] = port_data(w);
        end
    end

    always_comb begin
        rdat_d = '0;
        for (int r = 0; r < NRD; r++) begin
            int w;
            w = rf_winner(write_hits(rsel[r]));
            if (ZERO_REG != 0 && rsel[r] == '0) begin
                rdat_d[r] = '0;
            end else if (w >= 0) begin
                rdat_d[r] = port_data(w);
            end else begin
                rdat_d[r] = regs_q[rsel[r]];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            regs_q <= '0;
            rdat_q <= '0;
        end else begin
            regs_q <= regs_d;
            rdat_q <= rdat_d;
        end
    end

    assign rdat = rdat_q;

`ifdef RF_SCOREBOARD_EN
    rf_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .CLK      (CLK),
        .nRST     (nRST),
        .wen      (wen),
        .wsel     (wsel),
        .rsv_en   (rsv_en),
        .rsv_sel  (rsv_sel),
        .sb_flush (sb_flush),
        .rsel     (rsel),
        .rbusy    (rbusy)
    );
`endif

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed and model-checked bench for multiport_register_file (two ports each, plus a
// ZERO_REG=0 instance); scoreboard checks run when RF_SCOREBOARD_EN is defined.
module tb_multiport_register_file;

    logic CLK;
    logic nRST;

    logic [1:0]       wen;
    logic [1:0][4:0]  wsel;
    logic [1:0][31:0] wdat;
    logic [1:0][4:0]  rsel;
    logic [1:0][31:0] rdat;

    logic [0:0]       nz_wen;
    logic [0:0][4:0]  nz_wsel;
    logic [0:0][31:0] nz_wdat;
    logic [0:0][4:0]  nz_rsel;
    logic [0:0][31:0] nz_rdat;

`ifdef RF_SCOREBOARD_EN
    logic       rsv_en;
    logic [4:0] rsv_sel;
    logic       sb_flush;
    logic [1:0] rbusy;
    logic [0:0] nz_rbusy;
`endif

    int n_checks;
    int n_errors;
    logic [31:0] mdl [32];

    multiport_register_file #(
        .DATA_W   (32),
        .NREGS    (32),
        .NRD      (2),
        .NWR      (2),
        .ZERO_REG (1)
    ) u_dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .wen      (wen),
        .wsel     (wsel),
        .wdat     (wdat),
        .rsel     (rsel),
`ifdef RF_SCOREBOARD_EN
        .rsv_en   (rsv_en),
        .rsv_sel  (rsv_sel),
        .sb_flush (sb_flush),
        .rbusy    (rbusy),
`endif
        .rdat     (rdat)
    );

    multiport_register_file #(
        .DATA_W   (32),
        .NREGS    (32),
        .NRD      (1),
        .NWR      (1),
        .ZERO_REG (0)
    ) u_dut_nz (
        .CLK      (CLK),
        .nRST     (nRST),
        .wen      (nz_wen),
        .wsel     (nz_wsel),
        .wdat     (nz_wdat),
        .rsel     (nz_rsel),
`ifdef RF_SCOREBOARD_EN
        .rsv_en   (1'b0),
        .rsv_sel  (5'd0),
        .sb_flush (1'b0),
        .rbusy    (nz_rbusy),
`endif
        .rdat     (nz_rdat)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        nRST     = 1'b0;
        wen      = '0;
        wsel     = '0;
        wdat     = '0;
        rsel     = '0;
        nz_wen   = '0;
        nz_wsel  = '0;
        nz_wdat  = '0;
        nz_rsel  = '0;
`ifdef RF_SCOREBOARD_EN
        rsv_en   = 1'b0;
        rsv_sel  = '0;
        sb_flush = 1'b0;
`endif
        repeat (2) step();
        check("reset_rdat0", rdat[0], 32'h0);
        check("reset_rdat1", rdat[1], 32'h0);
        nRST = 1'b1;

        // Reset: async clear mid-cycle, in-flight write discarded
        wen = 2'b01; wsel[0] = 5'd5; wdat[0] = 32'hDEADBEEF; rsel[0] = 5'd5; rsel[1] = 5'd5;
        step();
        check("pre_reset_r5_p0", rdat[0], 32'hDEADBEEF);
        check("pre_reset_r5_p1", rdat[1], 32'hDEADBEEF);
        wdat[0] = 32'h11111111;
        #2 nRST = 1'b0;
        #1;
        check("async_reset_p0", rdat[0], 32'h0);
        check("async_reset_p1", rdat[1], 32'h0);
        step();
        wen = '0;
        nRST = 1'b1;
        step();
        check("r5_after_reset", rdat[0], 32'h0);

        // Forwarding, then stored value on the other port
        wen = 2'b01; wsel[0] = 5'd7; wdat[0] = 32'h1234; rsel[0] = 5'd7; rsel[1] = 5'd5;
        step();
        check("fwd_r7", rdat[0], 32'h1234);
        check("fwd_other_port", rdat[1], 32'h0);
        wen = '0; rsel[1] = 5'd7;
        step();
        check("stored_r7", rdat[1], 32'h1234);

        // Write conflict: port 1 wins
        wen = 2'b11; wsel[0] = 5'd3; wsel[1] = 5'd3;
        wdat[0] = 32'hAAAA; wdat[1] = 32'h5555; rsel[0] = 5'd3; rsel[1] = 5'd7;
        step();
        check("conflict_fwd", rdat[0], 32'h5555);
        check("conflict_keep_r7", rdat[1], 32'h1234);
        wen = '0; rsel[1] = 5'd3;
        step();
        check("conflict_stored_p0", rdat[0], 32'h5555);
        check("conflict_stored_p1", rdat[1], 32'h5555);

        // Two ports, distinct addresses, both forwarded
        wen = 2'b11; wsel[0] = 5'd10; wsel[1] = 5'd31;
        wdat[0] = 32'hCAFE0001; wdat[1] = 32'hCAFE0002; rsel[0] = 5'd31; rsel[1] = 5'd10;
        step();
        check("dual_fwd_r31", rdat[0], 32'hCAFE0002);
        check("dual_fwd_r10", rdat[1], 32'hCAFE0001);

        // Zero register on both configurations
        wen = 2'b01; wsel[0] = 5'd0; wdat[0] = 32'hFFFFFFFF; rsel[0] = 5'd0; rsel[1] = 5'd0;
        nz_wen = 1'b1; nz_wsel[0] = 5'd0; nz_wdat[0] = 32'hFFFFFFFF; nz_rsel[0] = 5'd0;
        step();
        check("zero_fwd", rdat[0], 32'h0);
        check("nonzero_fwd", nz_rdat[0], 32'hFFFFFFFF);
        wen = '0; nz_wen = '0;
        step();
        check("zero_stored", rdat[1], 32'h0);
        check("nonzero_stored", nz_rdat[0], 32'hFFFFFFFF);

`ifdef RF_SCOREBOARD_EN
        rsv_en = 1'b1; rsv_sel = 5'd9; rsel[0] = 5'd9; rsel[1] = 5'd3;
        step();
        check("sb_rsv_busy", {31'b0, rbusy[0]}, 32'h1);
        check("sb_other_free", {31'b0, rbusy[1]}, 32'h0);
        rsv_en = 1'b0; wen = 2'b10; wsel[1] = 5'd9; wdat[1] = 32'h99;
        step();
        check("sb_write_clear", {31'b0, rbusy[0]}, 32'h0);
        check("sb_write_data", rdat[0], 32'h99);
        rsv_en = 1'b1; rsv_sel = 5'd9; wen = 2'b01; wsel[0] = 5'd9; wdat[0] = 32'hAB;
        step();
        check("sb_rsv_and_write", {31'b0, rbusy[0]}, 32'h1);
        check("sb_rsv_and_write_data", rdat[0], 32'hAB);
        wen = '0; rsv_sel = 5'd2;
        step();
        sb_flush = 1'b1; rsv_sel = 5'd4; rsel[0] = 5'd4; rsel[1] = 5'd9;
        step();
        check("sb_flush_rsv", {30'b0, rbusy}, 32'h1);
        sb_flush = 1'b0; rsv_en = 1'b0; rsel[1] = 5'd2;
        step();
        check("sb_flush_cleared_r2", {30'b0, rbusy}, 32'h1);
        rsv_en = 1'b1; rsv_sel = 5'd0; rsel[0] = 5'd0;
        step();
        check("sb_zero_never_busy", {31'b0, rbusy[0]}, 32'h0);
        rsv_en = 1'b0;
`endif

        // Random traffic against a behavioural model, from a fresh reset
        wen = '0;
        nRST = 1'b0;
        #1 nRST = 1'b1;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        for (int c = 0; c < 2000; c++) begin
            wen = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                wsel[p] = 5'($urandom_range(0, 7));
                wdat[p] = $urandom;
                rsel[p] = 5'($urandom_range(0, 7));
            end
            if (c % 3 == 0) rsel[1] = rsel[0];
            if (c % 5 == 0) wsel[1] = wsel[0];
            for (int p = 0; p < 2; p++) begin
                if (wen[p] && wsel[p] != 5'd0) mdl[wsel[p]] = wdat[p];
            end
            step();
            check("rand_p0", rdat[0], mdl[rsel[0]]);
            check("rand_p1", rdat[1], mdl[rsel[1]]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
